vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
Banked, parametrised video RAM behind a single-ported storage array, with three requesters: PPU fetch, DMA write, and CPU read/write.
- Arbitrates one access per cycle with fixed priority.
- Applies the PPU mode-3 lockout to the CPU port and holds DMA off during lockout.
- Replaces the plain single-port VRAM: it sits between the bus decoder/DMA engine and the PPU fetcher.

Parameters:
ADDR_W, 13, address bits within one bank (bank depth 2^ADDR_W)
DATA_W, 8, data width
BANKS, 2, number of banks (power of two, >=1); BANK_W = max(1, $clog2(BANKS))

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
lock  input  1  PPU mode 3 active; CPU access blocked, DMA stalled
cpu_en  input  1  CPU request valid (held until accepted)
cpu_we  input  1  CPU write when 1, read when 0
cpu_addr  input  ADDR_W  CPU address within selected bank
cpu_din  input  DATA_W  CPU write data
cpu_ready  output  1  CPU request accepted this cycle (combinational)
cpu_dout  output  DATA_W  CPU read data
cpu_valid  output  1  one-cycle pulse: cpu_dout updated
bank_we  input  1  write bank-select register
bank_din  input  BANK_W  new bank-select value
bank_sel  output  BANK_W  current CPU/DMA bank
ppu_en  input  1  PPU read request
ppu_bank  input  BANK_W  PPU bank (independent of bank_sel)
ppu_addr  input  ADDR_W  PPU address
ppu_dout  output  DATA_W  PPU read data
ppu_valid  output  1  one-cycle pulse: ppu_dout updated
dma_en  input  1  DMA write request (held until accepted)
dma_addr  input  ADDR_W  DMA address, uses bank_sel
dma_din  input  DATA_W  DMA write data
dma_ready  output  1  DMA request accepted this cycle (combinational)

Behaviour:
- Storage: BANKS*2^ADDR_W words; physical index = {bank, addr}. Contents are not initialised or cleared by reset.
- Access rate: one storage access per cycle.
- Priority: PPU > DMA > CPU.
  - PPU is always served when ppu_en=1, including during lock.
  - dma_ready = dma_en & !ppu_en & !lock.
  - cpu_ready when lock=0: cpu_en & !ppu_en & !dma_en.
  - cpu_ready when lock=1: cpu_en (accepted without touching storage).
- Lockout (CPU accepted while lock=1):
  - Write: discarded, storage unchanged.
  - Read: cpu_dout = all ones, cpu_valid pulses next cycle.
  - lock is sampled in the accept cycle only.
- Read latency: exactly 1 cycle from acceptance (posedge after accept) to *_valid pulse with *_dout updated.
- Output hold: *_dout holds its last value between reads and never drives Z. *_valid is high for exactly one cycle per accepted read.
- Writes:
  - Accepted CPU/DMA writes commit at the acceptance edge.
  - A read of the same location on any later cycle returns the new data.
  - CPU writes produce no cpu_valid.
- Bank register:
  - bank_we updates bank_sel at the clock edge.
  - An access accepted in the same cycle uses the old bank_sel.
  - When BANKS is not a power of two, values >= BANKS are ignored (register unchanged).
- Simultaneous requests: the losers see ready=0 and must hold their request. No internal queueing; a blocked CPU/DMA request is not remembered by the block.
- Reset (asynchronous, any time):
  - cpu_dout=0, ppu_dout=0, cpu_valid=0, ppu_valid=0, bank_sel=0.
  - An in-flight read (accepted the cycle before reset) produces no valid pulse.
  - While reset is high, ready outputs are 0 and no writes commit.
- No state machine beyond the registered read-return stage (per port: valid flag plus data register) and bank_sel; all arbitration is combinational on current inputs.

Test Plan:
1. Reset, then CPU write 0x3C to 0x0010 (bank 0), CPU read 0x0010 -> cpu_ready=1 on both; cpu_valid pulses 1 cycle after the read accept with cpu_dout=0x3C.
2. bank_we=1, bank_din=1 in the same cycle as a CPU write 0xA5 @0x0000; next cycle CPU write 0x5A @0x0000; PPU reads bank0/bank1 @0x0000 -> bank0=0xA5, bank1=0x5A, bank_sel=1.
3. ppu_en, dma_en and cpu_en all asserted for 3 cycles -> only ppu_valid pulses and cpu_ready=dma_ready=0; drop ppu_en -> DMA accepted first, CPU accepted the following cycle.
4. lock=1, CPU write 0x77 @0x0020 then read 0x0020 -> both accepted immediately; read returns 0xFF. Then lock=0, read again -> old value (not 0x77). DMA held during lock -> dma_ready=0 until lock falls.
5. CPU read accepted, reset asserted asynchronously mid-cycle before the next edge -> no cpu_valid pulse; cpu_dout=0x00 and bank_sel=0 immediately; previously written memory contents are still readable after reset deasserts.
6. BANKS=4, ADDR_W=4: write distinct values to all 64 locations via DMA across banks, read back via PPU -> every value matches with 1-cycle latency, and address 0xF wraps into no other bank.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter
// Banked single-ported video RAM shared by three requesters with fixed
// priority PPU > DMA > CPU. Only one storage access is allowed per cycle.
// While the PPU is in mode 3 (lock), the CPU port is answered without
// touching storage and DMA is stalled.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   lock                        PPU mode 3: CPU locked out, DMA stalled
//   cpu_en/we/addr/din          CPU request (held by requester until cpu_ready)
//   cpu_ready                   CPU request accepted this cycle (combinational)
//   cpu_dout, cpu_valid         CPU read return, one cycle after accept
//   bank_we, bank_din, bank_sel bank-select register used by CPU and DMA
//   ppu_en/bank/addr            PPU read request, always served
//   ppu_dout, ppu_valid         PPU read return, one cycle after accept
//   dma_en/addr/din             DMA write request (held until dma_ready)
//   dma_ready                   DMA request accepted this cycle (combinational)
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int BANKS  = 2,
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lock,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_valid,
  input  logic              bank_we,
  input  logic [BANK_W-1:0] bank_din,
  output logic [BANK_W-1:0] bank_sel,
  input  logic              ppu_en,
  input  logic [BANK_W-1:0] ppu_bank,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic [DATA_W-1:0] ppu_dout,
  output logic              ppu_valid,
  input  logic              dma_en,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_din,
  output logic              dma_ready
);

  localparam int IDX_W = BANK_W + ADDR_W;
  localparam int DEPTH = 1 << IDX_W;

  function automatic logic [IDX_W-1:0] phys_idx(input logic [BANK_W-1:0] bank,
                                                input logic [ADDR_W-1:0] addr);
    return {bank, addr};
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic              cpu_mem;
  logic              cpu_rd;
  logic              bank_ok;
  logic [IDX_W-1:0]  cpu_idx;
  logic [IDX_W-1:0]  dma_idx;
  logic [IDX_W-1:0]  ppu_idx;

  logic [BANK_W-1:0] bank_sel_r;
  logic [DATA_W-1:0] cpu_dout_p1;
  logic [DATA_W-1:0] ppu_dout_p1;
  logic              cpu_vld_p1;
  logic              ppu_vld_p1;

  // Arbitration (stage 0): purely combinational on the current inputs.
  // Reset forces both ready lines low, which also blocks all writes.
  // Under lock the CPU is accepted regardless of PPU/DMA because it never
  // reaches storage.
  assign dma_ready = dma_en & ~ppu_en & ~lock & ~reset;
  assign cpu_ready = cpu_en & ~reset & (lock | (~ppu_en & ~dma_en));
  assign cpu_mem   = cpu_ready & ~lock;
  assign cpu_rd    = cpu_ready & ~cpu_we;

  // Bank values beyond BANKS-1 are dropped so bank_sel always names a real bank.
  assign bank_ok = 32'(bank_din) < 32'(BANKS);

  // CPU and DMA use the bank_sel value from before this edge.
  assign cpu_idx = phys_idx(bank_sel_r, cpu_addr);
  assign dma_idx = phys_idx(bank_sel_r, dma_addr);
  assign ppu_idx = phys_idx(ppu_bank, ppu_addr);

  // Storage: writes commit on the accepting edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (dma_ready) begin
      mem[dma_idx] <= dma_din;
    end else if (cpu_mem && cpu_we) begin
      mem[cpu_idx] <= cpu_din;
    end
  end

  // Read return (stage 1): one-cycle valid pulse with held data, plus bank_sel.
  // A locked-out CPU read returns all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_vld_p1  <= 1'b0;
      ppu_vld_p1  <= 1'b0;
      cpu_dout_p1 <= '0;
      ppu_dout_p1 <= '0;
      bank_sel_r  <= '0;
    end else begin
      ppu_vld_p1 <= ppu_en;
      if (ppu_en) begin
        ppu_dout_p1 <= mem[ppu_idx];
      end
      cpu_vld_p1 <= cpu_rd;
      if (cpu_rd) begin
        cpu_dout_p1 <= lock ? '1 : mem[cpu_idx];
      end
      if (bank_we && bank_ok) begin
        bank_sel_r <= bank_din;
      end
    end
  end

  assign cpu_dout  = cpu_dout_p1;
  assign cpu_valid = cpu_vld_p1;
  assign ppu_dout  = ppu_dout_p1;
  assign ppu_valid = ppu_vld_p1;
  assign bank_sel  = bank_sel_r;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  localparam int AW = 13;
  localparam int BW = 1;
  localparam int AWB = 4;
  localparam int BWB = 2;
  localparam int AWC = 2;
  localparam int BWC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance (defaults)
  logic          lock, cpu_en, cpu_we, cpu_ready, cpu_valid;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din, cpu_dout;
  logic          bank_we;
  logic [BW-1:0] bank_din, bank_sel, ppu_bank;
  logic          ppu_en, ppu_valid, dma_en, dma_ready;
  logic [AW-1:0] ppu_addr, dma_addr;
  logic [7:0]    ppu_dout, dma_din;

  vram_arbiter dut_a (
    .clk(clk), .reset(reset), .lock(lock),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ready(cpu_ready), .cpu_dout(cpu_dout), .cpu_valid(cpu_valid),
    .bank_we(bank_we), .bank_din(bank_din), .bank_sel(bank_sel),
    .ppu_en(ppu_en), .ppu_bank(ppu_bank), .ppu_addr(ppu_addr),
    .ppu_dout(ppu_dout), .ppu_valid(ppu_valid),
    .dma_en(dma_en), .dma_addr(dma_addr), .dma_din(dma_din), .dma_ready(dma_ready)
  );

  // 4 banks x 16 words
  logic           b_cpu_ready, b_cpu_valid, b_ppu_en, b_ppu_valid, b_dma_en, b_dma_ready, b_bank_we;
  logic [AWB-1:0] b_ppu_addr, b_dma_addr;
  logic [BWB-1:0] b_bank_din, b_bank_sel, b_ppu_bank;
  logic [7:0]     b_cpu_dout, b_ppu_dout, b_dma_din;

  vram_arbiter #(.ADDR_W(AWB), .DATA_W(8), .BANKS(4)) dut_b (
    .clk(clk), .reset(reset), .lock(1'b0),
    .cpu_en(1'b0), .cpu_we(1'b0), .cpu_addr(4'h0), .cpu_din(8'h00),
    .cpu_ready(b_cpu_ready), .cpu_dout(b_cpu_dout), .cpu_valid(b_cpu_valid),
    .bank_we(b_bank_we), .bank_din(b_bank_din), .bank_sel(b_bank_sel),
    .ppu_en(b_ppu_en), .ppu_bank(b_ppu_bank), .ppu_addr(b_ppu_addr),
    .ppu_dout(b_ppu_dout), .ppu_valid(b_ppu_valid),
    .dma_en(b_dma_en), .dma_addr(b_dma_addr), .dma_din(b_dma_din), .dma_ready(b_dma_ready)
  );

  // 3 banks: non power of two bank register
  logic           c_cpu_ready, c_cpu_valid, c_ppu_valid, c_dma_ready, c_bank_we;
  logic [BWC-1:0] c_bank_din, c_bank_sel;
  logic [7:0]     c_cpu_dout, c_ppu_dout;

  vram_arbiter #(.ADDR_W(AWC), .DATA_W(8), .BANKS(3)) dut_c (
    .clk(clk), .reset(reset), .lock(1'b0),
    .cpu_en(1'b0), .cpu_we(1'b0), .cpu_addr(2'h0), .cpu_din(8'h00),
    .cpu_ready(c_cpu_ready), .cpu_dout(c_cpu_dout), .cpu_valid(c_cpu_valid),
    .bank_we(c_bank_we), .bank_din(c_bank_din), .bank_sel(c_bank_sel),
    .ppu_en(1'b0), .ppu_bank(2'h0), .ppu_addr(2'h0),
    .ppu_dout(c_ppu_dout), .ppu_valid(c_ppu_valid),
    .dma_en(1'b0), .dma_addr(2'h0), .dma_din(8'h00), .dma_ready(c_dma_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model of dut_a: a word map keyed by bank*depth+addr, and the
  // values the outputs must show after each edge.
  logic [7:0]    mmem [int];
  logic [7:0]    e_cpu_dout = 8'h00, e_ppu_dout = 8'h00;
  logic          e_cpu_v = 1'b0, e_ppu_v = 1'b0;
  logic          e_cpu_known = 1'b1, e_ppu_known = 1'b1;
  logic [BW-1:0] e_bank = '0;
  logic          m_pa, m_da, m_ca;
  int            m_k;

  function automatic int key(input int b, input int a);
    return b * (1 << AW) + a;
  endfunction

  always begin
    @(posedge clk);
    if (reset) begin
      check("model_rst_cpu_ready", 32'(cpu_ready), 32'(0));
      check("model_rst_dma_ready", 32'(dma_ready), 32'(0));
      e_cpu_v = 1'b0; e_ppu_v = 1'b0;
      e_cpu_dout = 8'h00; e_ppu_dout = 8'h00;
      e_cpu_known = 1'b1; e_ppu_known = 1'b1;
      e_bank = '0;
    end else begin
      m_pa = ppu_en;
      m_da = dma_en && !ppu_en && !lock;
      m_ca = cpu_en && (lock || (!ppu_en && !dma_en));
      check("model_dma_ready", 32'(dma_ready), 32'(m_da));
      check("model_cpu_ready", 32'(cpu_ready), 32'(m_ca));
      e_ppu_v = m_pa;
      if (m_pa) begin
        m_k = key(int'(ppu_bank), int'(ppu_addr));
        e_ppu_known = mmem.exists(m_k);
        if (e_ppu_known) e_ppu_dout = mmem[m_k];
      end
      e_cpu_v = m_ca && !cpu_we;
      if (m_ca && !cpu_we) begin
        if (lock) begin
          e_cpu_dout = 8'hFF; e_cpu_known = 1'b1;
        end else begin
          m_k = key(int'(e_bank), int'(cpu_addr));
          e_cpu_known = mmem.exists(m_k);
          if (e_cpu_known) e_cpu_dout = mmem[m_k];
        end
      end
      if (m_da) mmem[key(int'(e_bank), int'(dma_addr))] = dma_din;
      else if (m_ca && cpu_we && !lock) mmem[key(int'(e_bank), int'(cpu_addr))] = cpu_din;
      if (bank_we) e_bank = bank_din;
    end
    #1;
    check("model_cpu_valid", 32'(cpu_valid), 32'(e_cpu_v));
    check("model_ppu_valid", 32'(ppu_valid), 32'(e_ppu_v));
    check("model_bank_sel", 32'(bank_sel), 32'(e_bank));
    if (e_cpu_known) check("model_cpu_dout", 32'(cpu_dout), 32'(e_cpu_dout));
    if (e_ppu_known) check("model_ppu_dout", 32'(ppu_dout), 32'(e_ppu_dout));
  end

  task automatic idle();
    lock = 0; cpu_en = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    bank_we = 0; bank_din = '0; ppu_en = 0; ppu_bank = '0; ppu_addr = '0;
    dma_en = 0; dma_addr = '0; dma_din = '0;
  endtask

  task automatic cpu_req(input logic we, input int addr, input logic [7:0] d);
    cpu_en = 1; cpu_we = we; cpu_addr = AW'(addr); cpu_din = d;
  endtask

  logic [7:0] exp_b;

  initial begin
    idle();
    b_bank_we = 0; b_bank_din = '0; b_ppu_en = 0; b_ppu_bank = '0; b_ppu_addr = '0;
    b_dma_en = 0; b_dma_addr = '0; b_dma_din = '0;
    c_bank_we = 0; c_bank_din = '0;
    reset = 1;
    cpu_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_dout", 32'(cpu_dout), 32'(0));
    check("rst_ppu_dout", 32'(ppu_dout), 32'(0));
    check("rst_cpu_valid", 32'(cpu_valid), 32'(0));
    check("rst_bank_sel", 32'(bank_sel), 32'(0));
    check("rst_cpu_ready", 32'(cpu_ready), 32'(0));
    @(negedge clk);
    reset = 0; idle();

    // write then read back through the CPU port
    @(negedge clk); cpu_req(1, 'h10, 8'h3C);
    #1 check("t1_wr_ready", 32'(cpu_ready), 32'(1));
    @(negedge clk);
    check("t1_no_valid_on_write", 32'(cpu_valid), 32'(0));
    cpu_req(0, 'h10, 8'h00);
    #1 check("t1_rd_ready", 32'(cpu_ready), 32'(1));
    @(negedge clk);
    check("t1_valid", 32'(cpu_valid), 32'(1));
    check("t1_dout", 32'(cpu_dout), 32'(8'h3C));
    idle();
    @(negedge clk);
    check("t1_valid_single", 32'(cpu_valid), 32'(0));

    // bank write in the same cycle as a CPU write uses the old bank
    bank_we = 1; bank_din = 1; cpu_req(1, 0, 8'hA5);
    @(negedge clk);
    check("t2_bank_sel", 32'(bank_sel), 32'(1));
    bank_we = 0; cpu_req(1, 0, 8'h5A);
    @(negedge clk);
    cpu_en = 0; ppu_en = 1; ppu_bank = 0; ppu_addr = '0;
    @(negedge clk);
    check("t2_ppu_bank0", 32'(ppu_dout), 32'(8'hA5));
    ppu_bank = 1;
    @(negedge clk);
    check("t2_ppu_bank1", 32'(ppu_dout), 32'(8'h5A));
    idle();

    // all three requesters at once
    @(negedge clk);
    ppu_en = 1; ppu_bank = 0; ppu_addr = AW'('h10);
    dma_en = 1; dma_addr = AW'('h40); dma_din = 8'h99;
    cpu_req(0, 'h40, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_cpu_blocked", 32'(cpu_ready), 32'(0));
      check("t3_dma_blocked", 32'(dma_ready), 32'(0));
      @(negedge clk);
      check("t3_ppu_valid", 32'(ppu_valid), 32'(1));
      check("t3_ppu_dout", 32'(ppu_dout), 32'(8'h3C));
    end
    ppu_en = 0;
    #1;
    check("t3_dma_first", 32'(dma_ready), 32'(1));
    check("t3_cpu_waits", 32'(cpu_ready), 32'(0));
    @(negedge clk);
    dma_en = 0;
    #1 check("t3_cpu_second", 32'(cpu_ready), 32'(1));
    @(negedge clk);
    check("t3_cpu_reads_dma", 32'(cpu_dout), 32'(8'h99));
    idle();

    // lockout
    @(negedge clk); cpu_req(1, 'h20, 8'h11);
    @(negedge clk);
    lock = 1; dma_en = 1; dma_addr = AW'('h30); dma_din = 8'h66;
    cpu_req(1, 'h20, 8'h77);
    #1;
    check("t4_lock_wr_ready", 32'(cpu_ready), 32'(1));
    check("t4_lock_dma_held", 32'(dma_ready), 32'(0));
    @(negedge clk);
    cpu_req(0, 'h20, 8'h00);
    #1;
    check("t4_lock_rd_ready", 32'(cpu_ready), 32'(1));
    check("t4_lock_dma_held2", 32'(dma_ready), 32'(0));
    @(negedge clk);
    check("t4_lock_valid", 32'(cpu_valid), 32'(1));
    check("t4_lock_ff", 32'(cpu_dout), 32'(8'hFF));
    lock = 0;
    #1;
    check("t4_dma_after_lock", 32'(dma_ready), 32'(1));
    check("t4_cpu_behind_dma", 32'(cpu_ready), 32'(0));
    @(negedge clk);
    dma_en = 0;
    #1 check("t4_cpu_rd_ready", 32'(cpu_ready), 32'(1));
    @(negedge clk);
    check("t4_old_value", 32'(cpu_dout), 32'(8'h11));
    idle();

    // asynchronous reset during an accepted read
    @(negedge clk); cpu_req(0, 'h10, 8'h00);
    #1 check("t5_ready_before_rst", 32'(cpu_ready), 32'(1));
    #1 reset = 1;
    #1;
    check("t5_dout_async", 32'(cpu_dout), 32'(0));
    check("t5_bank_async", 32'(bank_sel), 32'(0));
    check("t5_ready_in_rst", 32'(cpu_ready), 32'(0));
    @(posedge clk); #1;
    check("t5_no_valid", 32'(cpu_valid), 32'(0));
    @(negedge clk);
    reset = 0; idle();
    @(negedge clk); cpu_req(0, 'h10, 8'h00);
    @(negedge clk);
    check("t5_mem_kept_cpu", 32'(cpu_dout), 32'(8'h3C));
    idle(); ppu_en = 1; ppu_bank = 1; ppu_addr = '0;
    @(negedge clk);
    check("t5_mem_kept_ppu", 32'(ppu_dout), 32'(8'h5A));
    idle();

    // 4 banks x 16: fill every location via DMA, read all back via PPU
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      b_dma_en = 0; b_bank_we = 1; b_bank_din = BWB'(b);
      for (int a = 0; a < 16; a++) begin
        @(negedge clk);
        b_bank_we = 0; b_dma_en = 1; b_dma_addr = AWB'(a); b_dma_din = 8'(b * 16 + a + 1);
        #1 check("t6_dma_ready", 32'(b_dma_ready), 32'(1));
      end
    end
    @(negedge clk);
    b_dma_en = 0;
    check("t6_bank_sel", 32'(b_bank_sel), 32'(3));
    exp_b = 8'h00;
    for (int i = 0; i <= 64; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("t6_ppu_valid", 32'(b_ppu_valid), 32'(1));
        check("t6_ppu_dout", 32'(b_ppu_dout), 32'(exp_b));
      end
      if (i < 64) begin
        b_ppu_en = 1; b_ppu_bank = BWB'(i / 16); b_ppu_addr = AWB'(i % 16);
        exp_b = 8'(i + 1);
      end else begin
        b_ppu_en = 0;
      end
    end
    @(negedge clk);
    check("t6_ppu_valid_drop", 32'(b_ppu_valid), 32'(0));

    // non power of two bank count
    c_bank_we = 1; c_bank_din = 2;
    @(negedge clk);
    check("t7_bank2", 32'(c_bank_sel), 32'(2));
    c_bank_din = 3;
    @(negedge clk);
    check("t7_bank3_ignored", 32'(c_bank_sel), 32'(2));
    c_bank_din = 1;
    @(negedge clk);
    check("t7_bank1", 32'(c_bank_sel), 32'(1));
    c_bank_we = 0;

    // randomized traffic on the main instance, requests held until accepted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!cpu_en || cpu_ready) begin
        cpu_en = ($urandom_range(0, 99) < 50);
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom_range(0, 15));
        cpu_din = 8'($urandom);
      end
      if (!dma_en || dma_ready) begin
        dma_en = ($urandom_range(0, 99) < 30);
        dma_addr = AW'($urandom_range(0, 15));
        dma_din = 8'($urandom);
      end
      ppu_en = ($urandom_range(0, 99) < 25);
      ppu_bank = BW'($urandom_range(0, 1));
      ppu_addr = AW'($urandom_range(0, 15));
      lock = ($urandom_range(0, 99) < 20);
      bank_we = ($urandom_range(0, 99) < 5);
      bank_din = BW'($urandom_range(0, 1));
      reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    reset = 0; idle();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
